// File: rtl/rom_stream_dumper.sv
// Reads ROM from address 0 to LAST_ADDRESS and hands each word to a host that paces the
// transfer with a slow asynchronous sck strobe, acknowledging every consumed word.
module rom_stream_dumper #(
  parameter int unsigned               DATA_WIDTH    = 16,
  parameter int unsigned               ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  LAST_ADDRESS  = {ADDRESS_WIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump,
  input  logic                     sck,
  output logic                     output_valid,
  output logic [DATA_WIDTH-1:0]    output_data,
  output logic                     ack,
  output logic                     done,
  input  logic                     rom_busy,
  input  logic                     rom_initialized,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     rom_request,
  output logic [ADDRESS_WIDTH-1:0] rom_address
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitReady,
    StRequest,
    StReading,
    StPresent,
    StDone
  } state_e;

  state_e                   state_q, state_d;
  logic                     sck_s1_q, sck_s2_q, sck_s3_q;
  logic                     dump_q;
  logic                     rom_request_q, rom_request_d;
  logic                     output_valid_q, output_valid_d;
  logic [DATA_WIDTH-1:0]    output_data_q, output_data_d;
  logic                     ack_q, ack_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] rom_address_q, rom_address_d;

  logic sck_rise;
  logic dump_rise;
  logic rom_ready;

  assign sck_rise  = sck_s2_q & ~sck_s3_q;
  assign dump_rise = dump & ~dump_q;
  assign rom_ready = ~rom_busy & rom_initialized;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      sck_s1_q       <= 1'b0;
      sck_s2_q       <= 1'b0;
      sck_s3_q       <= 1'b0;
      dump_q         <= 1'b0;
      rom_request_q  <= 1'b0;
      output_valid_q <= 1'b0;
      output_data_q  <= '0;
      ack_q          <= 1'b0;
      done_q         <= 1'b0;
      rom_address_q  <= '0;
    end else begin
      state_q        <= state_d;
      sck_s1_q       <= sck;
      sck_s2_q       <= sck_s1_q;
      sck_s3_q       <= sck_s2_q;
      dump_q         <= dump;
      rom_request_q  <= rom_request_d;
      output_valid_q <= output_valid_d;
      output_data_q  <= output_data_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
      rom_address_q  <= rom_address_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rom_request_d  = rom_request_q;
    output_valid_d = output_valid_q;
    output_data_d  = output_data_q;
    ack_d          = 1'b0;
    done_d         = done_q;
    rom_address_d  = rom_address_q;

    // Dropping dump aborts from anywhere; an in-flight ROM read is left to finish on its own.
    if (state_q != StIdle && !dump) begin
      state_d        = StIdle;
      rom_request_d  = 1'b0;
      output_valid_d = 1'b0;
      done_d         = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dump_rise) begin
            rom_address_d = '0;
            done_d        = 1'b0;
            state_d       = StWaitReady;
          end
        end
        StWaitReady: begin
          if (rom_ready) begin
            rom_request_d = 1'b1;
            state_d       = StRequest;
          end
        end
        StRequest: begin
          if (rom_busy) begin
            rom_request_d = 1'b0;
            state_d       = StReading;
          end
        end
        StReading: begin
          if (!rom_busy) begin
            output_data_d  = rom_data;
            output_valid_d = 1'b1;
            state_d        = StPresent;
          end
        end
        StPresent: begin
          if (sck_rise) begin
            output_valid_d = 1'b0;
            ack_d          = 1'b1;
            if (rom_address_q == LAST_ADDRESS) begin
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              rom_address_d = rom_address_q + 1'b1;
              state_d       = StWaitReady;
            end
          end
        end
        StDone: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign rom_request  = rom_request_q;
  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;
  assign ack          = ack_q;
  assign done         = done_q;
  assign rom_address  = rom_address_q;

endmodule

// File: doc/rom_stream_dumper.md
Name: rom_stream_dumper

Overview:
- Read-back counterpart of the ROM stream loader: on host request, reads ROM sequentially from address 0 to LAST_ADDRESS and presents each word to an external host.
- The host paces the transfer with a slow, asynchronous sck. Each host sck rising edge consumes the presented word; the block answers with an ack pulse.
- Sits between the hack_soc ROM request/busy port and the host-side pins used for verifying ROM contents after loading.

Parameters:
- DATA_WIDTH, 16, width of a ROM word.
- ADDRESS_WIDTH, 16, width of the ROM address.
- LAST_ADDRESS, {ADDRESS_WIDTH{1'b1}}, final address read in one dump (inclusive).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dump  input  1  level; rising edge starts a dump, low aborts/ends it.
- sck  input  1  host strobe, asynchronous to clk; rising edge consumes current word.
- output_valid  output  1  output_data holds a valid word not yet consumed.
- output_data  output  DATA_WIDTH  word read from rom_address.
- ack  output  1  one-clk pulse: word consumed.
- done  output  1  last word consumed; held until dump goes low.
- rom_busy  input  1  ROM busy with an access.
- rom_initialized  input  1  ROM ready for use.
- rom_data  input  DATA_WIDTH  ROM read data; valid in the first cycle rom_busy is low after an access.
- rom_request  output  1  read request to ROM.
- rom_address  output  ADDRESS_WIDTH  current read address.

Behaviour:
- Reset: state=IDLE. rom_request=0, output_valid=0, ack=0, done=0, output_data=0, rom_address=0. sck synchroniser flops and the dump-edge flop cleared.
- sck path: 3-flop chain s1←sck, s2←s1, s3←s2. sck_rise = s2 & ~s3. A host edge first sampled at clk edge k acts at edge k+2; ack is visible after edge k+2.
- dump_rise = dump & ~dump_q, where dump_q is registered dump.
- rom_ready = ~rom_busy & rom_initialized.
- IDLE: on dump_rise → rom_address=0, done=0, go to WAIT_READY.
- WAIT_READY: if rom_ready → rom_request=1, go to REQUEST.
- REQUEST: rom_request held high until rom_busy is sampled high. That cycle: rom_request=0, go to READING.
- READING: on the first cycle with rom_busy=0 → output_data←rom_data, output_valid=1, go to PRESENT.
- PRESENT: output_data stable. On sck_rise:
  - output_valid=0 and ack=1 for exactly one cycle.
  - If rom_address==LAST_ADDRESS → done=1, go to DONE. rom_address does not increment or wrap.
  - Else rom_address+1, go to WAIT_READY.
- DONE: done=1. Any sck edges are ignored.
- sck_rise outside PRESENT is ignored: no ack, and no word is skipped.
- dump low in any state except IDLE: the next cycle is IDLE with rom_request=0, output_valid=0, done=0. rom_address keeps its value. An in-flight ROM read completes unobserved.
- A new dump_rise is accepted only in IDLE. It always restarts at address 0.
- rom_request never rises unless rom_ready was true in the same cycle it was set. rom_request and output_valid are never both 1.
- rom_initialized low blocks WAIT_READY indefinitely. No other timeout exists.
- Reset has priority over every other event, including mid-dump. All state is discarded.
- Throughput: at most one word per sck period. Minimum ROM-to-present latency is 3 clk from WAIT_READY, given a 1-cycle busy.

Test Plan:
- LAST_ADDRESS=3, ROM holds 0xA000..0xA003, busy lasts 4 cycles per read. Raise dump, give 4 sck pulses (8 clk high/8 low) → output_data sequence A000, A001, A002, A003. Four 1-cycle ack pulses. done=1 after the fourth; rom_address stays 3.
- rom_initialized=0 for 50 cycles after dump rises → rom_request stays 0, then asserts within 1 cycle of rom_initialized=1. First word is at address 0.
- Extra sck pulses during READING and in DONE → no ack, no address change, data sequence unchanged.
- Drop dump while in PRESENT at address 2, then raise it again → output_valid=0 and IDLE within 1 cycle. Restart presents the word at address 0.
- Assert reset while in REQUEST → all outputs 0 next cycle. A following dump starts cleanly at address 0.
- sck glitch 1 clk wide (shorter than the synchroniser) vs a 3-clk-wide pulse → the wide pulse yields exactly one ack. Hold sck high for 20 cycles → only one word consumed.
